// File: rtl/bcd_cascade_counter.sv
// Multi-digit modulo-R up/down counter: D cascaded N-bit digits acting as one number,
// with clear, range-checked parallel load, and wrap or saturate at terminal count.
module bcd_cascade_counter #(
  parameter int N   = 4,
  parameter int R   = 10,
  parameter int D   = 3,
  parameter int SAT = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           load,
  input  logic [D*N-1:0] load_val,
  input  logic           enable,
  input  logic           up,
  output logic [D*N-1:0] qout,
  output logic           cout,
  output logic           wrap,
  output logic           load_err
);

  // Radix held one bit wider so R = 2^N still compares correctly.
  localparam logic [N:0]   RADIX     = R[N:0];
  localparam logic [N:0]   TOP_W     = RADIX - 1'b1;
  localparam logic [N-1:0] TOP       = TOP_W[N-1:0];
  localparam bit           SATURATE  = (SAT != 0);

  logic [D*N-1:0] step_val;
  logic           tc;
  logic [D*N-1:0] ld_val;
  logic           ld_bad;

  // A digit moves only while every lower digit sits at its rollover value;
  // the running chain after the last digit is exactly the terminal-count condition.
  always_comb begin : step_logic
    logic         chain;
    logic [N-1:0] dig;
    step_val = qout;
    chain    = 1'b1;
    dig      = '0;
    for (int k = 0; k < D; k++) begin
      dig = qout[k*N +: N];
      if (chain) begin
        if (up) step_val[k*N +: N] = (dig == TOP) ? '0 : dig + 1'b1;
        else    step_val[k*N +: N] = (dig == '0) ? TOP : dig - 1'b1;
      end
      chain = chain & (up ? (dig == TOP) : (dig == '0));
    end
    tc = chain;
  end

  always_comb begin : load_check
    logic [N-1:0] dig;
    ld_val = '0;
    ld_bad = 1'b0;
    dig    = '0;
    for (int k = 0; k < D; k++) begin
      dig = load_val[k*N +: N];
      if ({1'b0, dig} >= RADIX) begin
        ld_val[k*N +: N] = TOP;
        ld_bad           = 1'b1;
      end else begin
        ld_val[k*N +: N] = dig;
      end
    end
  end

  assign cout = enable & tc & ~clear & ~load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qout     <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        qout <= '0;
      end else if (load) begin
        qout     <= ld_val;
        load_err <= ld_bad;
      end else if (enable && !(tc && SATURATE)) begin
        qout <= step_val;
        wrap <= tc;
      end
    end
  end

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Bench for bcd_cascade_counter: three instances (BCD wrap, BCD saturate, radix-6),
// directed steps then random traffic, checked against an integer-valued model.
module tb_bcd_cascade_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: N=4 R=10 D=3 SAT=0
  logic        clr_a, ld_a, en_a, up_a, cout_a, wrap_a, le_a;
  logic [11:0] lv_a, q_a;
  // Instance S: N=4 R=10 D=3 SAT=1
  logic        clr_s, ld_s, en_s, up_s, cout_s, wrap_s, le_s;
  logic [11:0] lv_s, q_s;
  // Instance B: N=3 R=6 D=2 SAT=0
  logic        clr_b, ld_b, en_b, up_b, cout_b, wrap_b, le_b;
  logic [5:0]  lv_b, q_b;

  bcd_cascade_counter #(.N(4), .R(10), .D(3), .SAT(0)) dut_a (
    .clk(clk), .reset(reset), .clear(clr_a), .load(ld_a), .load_val(lv_a),
    .enable(en_a), .up(up_a), .qout(q_a), .cout(cout_a), .wrap(wrap_a), .load_err(le_a));

  bcd_cascade_counter #(.N(4), .R(10), .D(3), .SAT(1)) dut_s (
    .clk(clk), .reset(reset), .clear(clr_s), .load(ld_s), .load_val(lv_s),
    .enable(en_s), .up(up_s), .qout(q_s), .cout(cout_s), .wrap(wrap_s), .load_err(le_s));

  bcd_cascade_counter #(.N(3), .R(6), .D(2), .SAT(0)) dut_b (
    .clk(clk), .reset(reset), .clear(clr_b), .load(ld_b), .load_val(lv_b),
    .enable(en_b), .up(up_b), .qout(q_b), .cout(cout_b), .wrap(wrap_b), .load_err(le_b));

  int checks   = 0;
  int failures = 0;
  int mv[3];       // model value of each instance as a plain integer
  int wraps_b;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ipow(input int r, input int d);
    int p = 1;
    for (int k = 0; k < d; k++) p = p * r;
    return p;
  endfunction

  function automatic logic [11:0] pack(input int v, input int r, input int d, input int n);
    logic [11:0] res = '0;
    int x = v;
    for (int k = 0; k < d; k++) begin
      res = res | (12'(x % r) << (k * n));
      x = x / r;
    end
    return res;
  endfunction

  // Instance geometry: sel 0 = A, 1 = S, 2 = B
  function automatic int g_r(input int sel);   return (sel == 2) ? 6 : 10; endfunction
  function automatic int g_d(input int sel);   return (sel == 2) ? 2 : 3;  endfunction
  function automatic int g_n(input int sel);   return (sel == 2) ? 3 : 4;  endfunction
  function automatic bit g_sat(input int sel); return (sel == 1);          endfunction

  // Model works on the counter's numeric value, not its digits.
  function automatic void model_step(input int sel, input int v, input bit clr, input bit ld,
                                     input logic [11:0] lv, input bit en, input bit u,
                                     output int nv, output bit w, output bit le);
    int r = g_r(sel), d = g_d(sel), n = g_n(sel);
    int top = ipow(r, d) - 1;
    int mult = 1;
    int dg;
    nv = v; w = 1'b0; le = 1'b0;
    if (clr) begin
      nv = 0;
    end else if (ld) begin
      nv = 0;
      for (int k = 0; k < d; k++) begin
        dg = int'((lv >> (k * n)) & ((12'd1 << n) - 12'd1));
        if (dg >= r) begin dg = r - 1; le = 1'b1; end
        nv = nv + dg * mult;
        mult = mult * r;
      end
    end else if (en) begin
      if (u) begin
        if (v == top) begin
          if (!g_sat(sel)) begin nv = 0; w = 1'b1; end
        end else nv = v + 1;
      end else begin
        if (v == 0) begin
          if (!g_sat(sel)) begin nv = top; w = 1'b1; end
        end else nv = v - 1;
      end
    end
  endfunction

  function automatic bit model_cout(input int sel, input int v, input bit clr, input bit ld,
                                    input bit en, input bit u);
    int top = ipow(g_r(sel), g_d(sel)) - 1;
    return en && !clr && !ld && (u ? (v == top) : (v == 0));
  endfunction

  task automatic set_idle();
    {clr_a, ld_a, en_a, up_a} = 4'b0001; lv_a = '0;
    {clr_s, ld_s, en_s, up_s} = 4'b0001; lv_s = '0;
    {clr_b, ld_b, en_b, up_b} = 4'b0001; lv_b = '0;
  endtask

  // One clock of traffic on one instance; others idle and hold.
  task automatic cyc(input int sel, input bit clr, input bit ld, input logic [11:0] lv,
                     input bit en, input bit u);
    int nv;
    bit w, le;
    logic [11:0] oq;
    logic ocout, owrap, ole;
    set_idle();
    case (sel)
      0: begin clr_a = clr; ld_a = ld; lv_a = lv;      en_a = en; up_a = u; end
      1: begin clr_s = clr; ld_s = ld; lv_s = lv;      en_s = en; up_s = u; end
      default: begin clr_b = clr; ld_b = ld; lv_b = lv[5:0]; en_b = en; up_b = u; end
    endcase
    #1;
    ocout = (sel == 0) ? cout_a : (sel == 1) ? cout_s : cout_b;
    check($sformatf("cout%0d", sel), {11'd0, ocout},
          {11'd0, model_cout(sel, mv[sel], clr, ld, en, u)});
    model_step(sel, mv[sel], clr, ld, (sel == 2) ? {6'd0, lv[5:0]} : lv, en, u, nv, w, le);
    @(posedge clk);
    #1;
    mv[sel] = nv;
    oq    = (sel == 0) ? q_a    : (sel == 1) ? q_s    : {6'd0, q_b};
    owrap = (sel == 0) ? wrap_a : (sel == 1) ? wrap_s : wrap_b;
    ole   = (sel == 0) ? le_a   : (sel == 1) ? le_s   : le_b;
    check($sformatf("qout%0d", sel), oq, pack(nv, g_r(sel), g_d(sel), g_n(sel)));
    check($sformatf("wrap%0d", sel), {11'd0, owrap}, {11'd0, w});
    check($sformatf("lerr%0d", sel), {11'd0, ole}, {11'd0, le});
  endtask

  task automatic step_a(input bit u); cyc(0, 1'b0, 1'b0, 12'h000, 1'b1, u); endtask

  initial begin
    bit rc, rl, re, ru;
    logic [11:0] rv;
    reset = 1'b1;
    set_idle();
    mv[0] = 0; mv[1] = 0; mv[2] = 0;
    @(posedge clk); #1;
    check("rst_q_a", q_a, 12'h000);
    check("rst_flags_a", {10'd0, wrap_a, le_a}, 12'h000);
    check("rst_q_b", {6'd0, q_b}, 12'h000);
    reset = 1'b0;

    // Count a little, then hit reset between edges while still enabled.
    for (int i = 0; i < 7; i++) step_a(1'b1);
    en_a = 1'b1; up_a = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("midrst_q", q_a, 12'h000);
    check("midrst_flags", {10'd0, wrap_a, le_a}, 12'h000);
    @(posedge clk); #1;
    reset = 1'b0;
    mv[0] = 0;

    // 1000 up-steps through every carry and the final wrap.
    for (int i = 1; i <= 1000; i++) begin
      step_a(1'b1);
      if (i == 10)   check("q_010", q_a, 12'h010);
      if (i == 100)  check("q_100", q_a, 12'h100);
      if (i == 999)  check("q_999", q_a, 12'h999);
      if (i == 1000) check("wrap_1000", {11'd0, wrap_a}, 12'h001);
    end
    cyc(0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    check("wrap_one_cycle", {11'd0, wrap_a}, 12'h000);

    // Borrow and downward wrap.
    cyc(0, 1'b0, 1'b1, 12'h100, 1'b0, 1'b0);
    step_a(1'b0);
    check("borrow_099", q_a, 12'h099);
    cyc(0, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0);
    step_a(1'b0);
    check("down_wrap_999", q_a, 12'h999);
    check("down_wrap_flag", {11'd0, wrap_a}, 12'h001);

    // Priority: clear beats load beats enable.
    cyc(0, 1'b1, 1'b1, 12'h555, 1'b1, 1'b1);
    check("prio_clear", q_a, 12'h000);
    cyc(0, 1'b0, 1'b1, 12'h555, 1'b1, 1'b1);
    check("prio_load", q_a, 12'h555);

    // Out-of-range digits clamp to R-1.
    cyc(0, 1'b0, 1'b1, 12'hA3F, 1'b0, 1'b1);
    check("clamp_q", q_a, 12'h939);
    check("clamp_err", {11'd0, le_a}, 12'h001);
    cyc(0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    check("clamp_err_clr", {11'd0, le_a}, 12'h000);

    // Saturating instance.
    cyc(1, 1'b0, 1'b1, 12'h998, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      check("sat_q", q_s, 12'h999);
      check("sat_nowrap", {11'd0, wrap_s}, 12'h000);
    end
    cyc(1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    check("sat_down", q_s, 12'h998);

    // Radix-6, two digits: full cycle of 36.
    cyc(2, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
    wraps_b = 0;
    for (int i = 0; i < 36; i++) begin
      cyc(2, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
      if (wrap_b) wraps_b++;
      check("b_d0_le5", {11'd0, (q_b[2:0] <= 3'd5)}, 12'h001);
    end
    check("b_back_to_00", {6'd0, q_b}, 12'h000);
    check("b_one_wrap", 12'(wraps_b), 12'd1);

    // Random traffic on every instance.
    for (int sel = 0; sel < 3; sel++) begin
      for (int i = 0; i < 300; i++) begin
        int roll = $urandom_range(0, 99);
        rc = (roll < 4);
        rl = (roll >= 4) && (roll < 16);
        re = ($urandom_range(0, 3) != 0);
        ru = $urandom_range(0, 1) != 0;
        rv = 12'($urandom);
        cyc(sel, rc, rl, rv, re, ru);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
